debounce_pulse: RTL and testbench
=================================

Name: debounce_pulse

Overview:
Conditions a raw, asynchronous, bouncing push-button or switch input into a clean level and single-cycle edge pulses. It sits directly upstream of the FFD stage: `rise` drives the flip-flop's enable and `level` drives its D, so each press is registered exactly once. It consists of a 2-FF synchronizer, a stability counter and a 4-state FSM.

Parameters:
STABLE_CYCLES, 500000, consecutive synchronized samples at the new value required before accepting a change (10 ms at 50 MHz); must be >= 1
CNT_W, $clog2(STABLE_CYCLES+1), width of the stability counter; derived, not overridden

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  asynchronous, active-low reset; asserted when 0, and all registers clear immediately
btn  input  1  raw, asynchronous, possibly bouncing input
level  output  1  debounced level of btn, registered
rise  output  1  one-cycle pulse when level goes 0->1, registered
fall  output  1  one-cycle pulse when level goes 1->0, registered

Behaviour:
- Reset (reset=0, asynchronous): sync stages=0, cnt=0, state=S_LOW, level=0, rise=0, fall=0. On release, the first update happens at the next rising clk edge.
- Synchronizer: s1<=btn, s2<=s1. din_s=s2. Nothing else samples btn directly.
- FSM states: S_LOW, S_LOW_TO_HIGH, S_HIGH, S_HIGH_TO_LOW. level=1 in S_HIGH and S_HIGH_TO_LOW, else 0. level is held in a register, not decoded combinationally.
- S_LOW:
  - din_s=1 -> S_LOW_TO_HIGH, cnt<=1.
  - Exception: if STABLE_CYCLES=1 -> S_HIGH directly, with level<=1 and rise<=1.
  - Otherwise stay, cnt<=0.
- S_LOW_TO_HIGH:
  - din_s=0 -> S_LOW, cnt<=0 (bounce rejected, no pulse).
  - din_s=1 and cnt=STABLE_CYCLES-1 -> S_HIGH, level<=1, rise<=1, cnt<=0.
  - Otherwise cnt<=cnt+1.
- S_HIGH and S_HIGH_TO_LOW: mirror images of the two states above, with din_s inverted; fall replaces rise.
- rise and fall default to 0 every cycle; each is high for exactly one cycle. They are never high together, and never high outside a level change.
- Latency: count the first edge at which s1 captures a new stable btn value as edge 1. level, rise and fall update on edge STABLE_CYCLES+2 (edge 6 for STABLE_CYCLES=4).
- Bounce shorter than STABLE_CYCLES samples: the counter restarts; level, rise and fall are unchanged.
- Counter never wraps: its maximum value is STABLE_CYCLES-1, and CNT_W holds that value.
- Reset mid-count: partial count is discarded and no pulse is emitted. After release, a btn held at 1 produces rise STABLE_CYCLES+2 edges later.
- btn changing in the same cycle the counter expires: the transition completes, using the din_s sampled on that edge. A new change starts a fresh count in the opposite direction on the following edge.

Decomposition:
- Shared include/package: 2-bit state encodings S_LOW=2'b00, S_LOW_TO_HIGH=2'b01, S_HIGH=2'b11, S_HIGH_TO_LOW=2'b10, and the STABLE_CYCLES default.
- One sub-module: sync_2ff (1-bit, async active-low reset to 0). It is reused by later input-conditioning blocks.

Test Plan (STABLE_CYCLES=4 for all scenarios):
- Clean press: btn 0->1 and held. Required: level=1 and rise=1 after edge 6, rise=0 after edge 7, fall stays 0.
- Bouncy press: btn toggles 1,0,1,0 on consecutive edges, then holds 1. Required: exactly one rise pulse, 6 edges after the final 0->1. level is never 1 before that.
- Glitch rejection: with level=1, btn drops to 0 for 3 cycles, then returns to 1. Required: level stays 1, fall never asserts.
- Release: with level=1, btn 1->0 and held. Required: level=0 and fall=1 after edge 6, fall=0 after edge 7.
- Async reset mid-count:
  - Pull reset=0 between clk edges, 2 edges into a rising count. Required: level, rise and cnt read 0 before the next clk edge.
  - Release reset with btn=1. Required: rise 6 edges later.
- Press-to-FFD chain: debounce_pulse drives the FFD's enable and D. Required: three debounced presses give three FFD loads of 1, and no extra loads during bounce.

Source files
------------

// File: rtl/debounce_pulse_pkg.sv
// Shared types for the debounce_pulse input conditioner.
// Holds the FSM state encoding and the default stability window.
package debounce_pulse_pkg;

    // 10 ms at 50 MHz
    localparam int unsigned STABLE_CYCLES_DEF = 500000;

    typedef enum logic [1:0] {
        S_LOW         = 2'b00,
        S_LOW_TO_HIGH = 2'b01,
        S_HIGH        = 2'b11,
        S_HIGH_TO_LOW = 2'b10
    } state_e;

endpackage

// File: rtl/debounce_pulse_if.sv
// Button-side bundle of debounce_pulse.
// btn: raw input; level/rise/fall: debounced level and edge pulses.
interface debounce_pulse_if;

    logic btn;
    logic level;
    logic rise;
    logic fall;

    modport master (
        output btn,
        input  level,
        input  rise,
        input  fall
    );

    modport slave (
        input  btn,
        output level,
        output rise,
        output fall
    );

endinterface

// File: rtl/debounce_pulse_sync_2ff.sv
// Two-flop synchronizer for one asynchronous bit.
// clk, rst_n (async, active-low, clears to 0), d_i raw, q_o synced.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/debounce_pulse.sv
// Debouncer: 2-FF sync, stability counter, 4-state FSM.
// clk, reset (async, active-low), bus.slave: btn in; level/rise/fall out.
module debounce_pulse
    import debounce_pulse_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             reset,
    debounce_pulse_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             din_s;
    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             level_q;
    logic             rise_q;
    logic             fall_q;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (reset),
        .d_i   (bus.btn),
        .q_o   (din_s)
    );

    // cnt_q holds how many consecutive samples have already
    // disagreed with level_q; the change is taken when the
    // next agreeing sample would make it STABLE_CYCLES.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            unique case (state_q)
                S_LOW: begin
                    if (din_s) begin
                        if (STABLE_CYCLES == 1) begin
                            state_q <= S_HIGH;
                            level_q <= 1'b1;
                            rise_q  <= 1'b1;
                            cnt_q   <= '0;
                        end else begin
                            state_q <= S_LOW_TO_HIGH;
                            cnt_q   <= CNT_ONE;
                        end
                    end else begin
                        cnt_q <= '0;
                    end
                end
                S_LOW_TO_HIGH: begin
                    if (!din_s) begin
                        state_q <= S_LOW;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_q <= S_HIGH;
                        level_q <= 1'b1;
                        rise_q  <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                S_HIGH: begin
                    if (!din_s) begin
                        if (STABLE_CYCLES == 1) begin
                            state_q <= S_LOW;
                            level_q <= 1'b0;
                            fall_q  <= 1'b1;
                            cnt_q   <= '0;
                        end else begin
                            state_q <= S_HIGH_TO_LOW;
                            cnt_q   <= CNT_ONE;
                        end
                    end else begin
                        cnt_q <= '0;
                    end
                end
                S_HIGH_TO_LOW: begin
                    if (din_s) begin
                        state_q <= S_HIGH;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_q <= S_LOW;
                        level_q <= 1'b0;
                        fall_q  <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
            endcase
        end
    end

    assign bus.level = level_q;
    assign bus.rise  = rise_q;
    assign bus.fall  = fall_q;

endmodule

// File: tb/tb_debounce_pulse.sv
// Self-checking bench for debounce_pulse with STABLE_CYCLES=4.
// Run-length model of the debouncer plus directed literal checks.
module tb_debounce_pulse;

    localparam int SC = 4;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    debounce_pulse_if bus ();

    debounce_pulse #(.STABLE_CYCLES(SC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic void chk(string n, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d at %0t", n, act, exp, $time);
        end
    endfunction

    // Model: btn reaches the decision logic two edges late;
    // level flips once SC consecutive samples disagree with it.
    logic h1, h2;
    logic m_level, m_rise, m_fall;
    int   m_run;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            h1      <= 1'b0;
            h2      <= 1'b0;
            m_level <= 1'b0;
            m_rise  <= 1'b0;
            m_fall  <= 1'b0;
            m_run   <= 0;
        end else begin
            h1     <= bus.btn;
            h2     <= h1;
            m_rise <= 1'b0;
            m_fall <= 1'b0;
            if (h2 != m_level) begin
                if (m_run + 1 == SC) begin
                    m_level <= h2;
                    m_rise  <= h2;
                    m_fall  <= !h2;
                    m_run   <= 0;
                end else begin
                    m_run <= m_run + 1;
                end
            end else begin
                m_run <= 0;
            end
        end
    end

    int rise_cnt = 0;
    int fall_cnt = 0;

    always @(negedge clk) begin
        chk("model_level", int'(bus.level), int'(m_level));
        chk("model_rise", int'(bus.rise), int'(m_rise));
        chk("model_fall", int'(bus.fall), int'(m_fall));
        chk("rise_fall_excl", int'(bus.rise & bus.fall), 0);
        if (bus.rise) rise_cnt++;
        if (bus.fall) fall_cnt++;
    end

    // Downstream FFD: rise is the enable, level is D.
    int   loads = 0;
    int   ones  = 0;
    logic ffd_q = 1'b0;

    always @(posedge clk) begin
        if (bus.rise) begin
            loads <= loads + 1;
            if (bus.level) ones <= ones + 1;
            ffd_q <= bus.level;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bounce_press();
        bus.btn = 1'b1; cyc(1);
        bus.btn = 1'b0; cyc(1);
        bus.btn = 1'b1; cyc(1);
        bus.btn = 1'b0; cyc(1);
        bus.btn = 1'b1;
    endtask

    int f0, r0, l0, o0;

    initial begin
        bus.btn = 1'b0;
        reset   = 1'b1;
        #1 reset = 1'b0;
        cyc(3);
        chk("rst_level", int'(bus.level), 0);
        chk("rst_rise", int'(bus.rise), 0);
        chk("rst_fall", int'(bus.fall), 0);
        chk("rst_cnt", int'(dut.cnt_q), 0);
        #2 reset = 1'b1;
        cyc(3);

        // clean press
        bus.btn = 1'b1;
        cyc(5);
        chk("press_e5_level", int'(bus.level), 0);
        chk("press_e5_rise", int'(bus.rise), 0);
        cyc(1);
        chk("press_e6_level", int'(bus.level), 1);
        chk("press_e6_rise", int'(bus.rise), 1);
        cyc(1);
        chk("press_e7_rise", int'(bus.rise), 0);
        chk("press_e7_level", int'(bus.level), 1);
        chk("press_fall", int'(bus.fall), 0);

        // glitch while high
        f0 = fall_cnt;
        bus.btn = 1'b0;
        cyc(3);
        bus.btn = 1'b1;
        cyc(10);
        chk("glitch_level", int'(bus.level), 1);
        chk("glitch_falls", fall_cnt, f0);

        // release
        bus.btn = 1'b0;
        cyc(5);
        chk("rel_e5_level", int'(bus.level), 1);
        chk("rel_e5_fall", int'(bus.fall), 0);
        cyc(1);
        chk("rel_e6_level", int'(bus.level), 0);
        chk("rel_e6_fall", int'(bus.fall), 1);
        cyc(1);
        chk("rel_e7_fall", int'(bus.fall), 0);
        cyc(5);

        // bouncy press
        r0 = rise_cnt;
        bounce_press();
        cyc(5);
        chk("bounce_e5_level", int'(bus.level), 0);
        chk("bounce_e5_rises", rise_cnt, r0);
        cyc(1);
        chk("bounce_e6_level", int'(bus.level), 1);
        chk("bounce_e6_rise", int'(bus.rise), 1);
        cyc(10);
        chk("bounce_rises", rise_cnt, r0 + 1);

        bus.btn = 1'b0;
        cyc(10);

        // async reset two edges into a rising count
        bus.btn = 1'b1;
        cyc(4);
        chk("mid_cnt", int'(dut.cnt_q), 2);
        #2 reset = 1'b0;
        #1;
        chk("arst_level", int'(bus.level), 0);
        chk("arst_rise", int'(bus.rise), 0);
        chk("arst_cnt", int'(dut.cnt_q), 0);
        cyc(2);
        #2 reset = 1'b1;
        cyc(5);
        chk("arel_e5_rise", int'(bus.rise), 0);
        chk("arel_e5_level", int'(bus.level), 0);
        cyc(1);
        chk("arel_e6_rise", int'(bus.rise), 1);
        chk("arel_e6_level", int'(bus.level), 1);
        cyc(1);

        bus.btn = 1'b0;
        cyc(10);

        // three bouncy presses into the FFD
        l0 = loads;
        o0 = ones;
        repeat (3) begin
            bounce_press();
            cyc(10);
            bus.btn = 1'b0; cyc(1);
            bus.btn = 1'b1; cyc(1);
            bus.btn = 1'b0;
            cyc(10);
        end
        chk("ffd_loads", loads - l0, 3);
        chk("ffd_ones", ones - o0, 3);
        chk("ffd_q", int'(ffd_q), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
